// File: rtl/ow_pkg.sv
`timescale 1ns/1ps
// ow_pkg: shared widths, default 1-wire timing and the sequencer state encoding.
package ow_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int BCNT_W = 6;

  localparam int DEF_T_SLOT    = 3500;
  localparam int DEF_T_LOW1    = 300;
  localparam int DEF_T_LOW0    = 3000;
  localparam int DEF_T_RST_LOW = 24000;
  localparam int DEF_T_PRES    = 3500;
  localparam int DEF_T_RST_TOT = 48000;
  localparam int DEF_T_RD_TO   = 15;

  typedef enum logic [3:0] {
    IDLE,
    RST_LOW,
    RST_WAIT,
    FETCH,
    WAIT_DATA,
    SLOT_LOW,
    SLOT_REL,
    NEXT,
    FINISH
  } ow_state_t;

  // A state that must last N cycles loads the tick counter with N-1 on entry
  // and leaves on the cycle the counter reads zero.
  function automatic logic [CNT_W-1:0] ticksToLoad(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ow_tick_counter.sv
`timescale 1ns/1ps
// ow_tick_counter: loadable down-counter that times every sequencer interval.
module ow_tick_counter
  import ow_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_value = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/ow_tx_sequencer.sv
`timescale 1ns/1ps
// ow_tx_sequencer: optional bus reset/presence check, then streams bytes
// fetched from a memory onto the 1-wire line as LSB-first write slots.
module ow_tx_sequencer
  import ow_pkg::*;
#(
  parameter int T_SLOT    = DEF_T_SLOT,
  parameter int T_LOW1    = DEF_T_LOW1,
  parameter int T_LOW0    = DEF_T_LOW0,
  parameter int T_RST_LOW = DEF_T_RST_LOW,
  parameter int T_PRES    = DEF_T_PRES,
  parameter int T_RST_TOT = DEF_T_RST_TOT,
  parameter int T_RD_TO   = DEF_T_RD_TO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              with_reset,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [BCNT_W-1:0] byte_count,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_dv,
  input  logic              dq_in,
  output logic              dq_pull_low,
  output logic              busy,
  output logic              done,
  output logic              presence_err,
  output logic              read_err
);

  localparam logic [CNT_W-1:0] L_RST_LOW  = ticksToLoad(T_RST_LOW);
  localparam logic [CNT_W-1:0] L_RST_WAIT = ticksToLoad(T_RST_TOT - T_RST_LOW);
  localparam logic [CNT_W-1:0] L_PRES_AT  = ticksToLoad(T_RST_TOT - T_RST_LOW - T_PRES);
  localparam logic [CNT_W-1:0] L_RD_TO    = ticksToLoad(T_RD_TO);
  localparam logic [CNT_W-1:0] L_LOW1     = ticksToLoad(T_LOW1);
  localparam logic [CNT_W-1:0] L_LOW0     = ticksToLoad(T_LOW0);
  localparam logic [CNT_W-1:0] L_REL1     = ticksToLoad(T_SLOT - T_LOW1);
  localparam logic [CNT_W-1:0] L_REL0     = ticksToLoad(T_SLOT - T_LOW0);

  ow_state_t         r_state;
  ow_state_t         w_nextState;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [BCNT_W-1:0] r_remain;
  logic [BCNT_W-1:0] w_nextRemain;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_bitIdx;
  logic              r_presence;

  logic              r_dqMeta;
  logic              r_dqSync;

  logic [ADDR_W-1:0] r_readAddress;
  logic              r_readEn;
  logic              r_dqPullLow;
  logic              r_busy;
  logic              r_done;
  logic              r_presErr;
  logic              r_readErr;

  logic              w_accept;
  logic              w_capture;
  logic              w_advanceBit;
  logic              w_setPresErr;
  logic              w_setReadErr;
  logic              w_presSample;

  logic              w_cntLoad;
  logic [CNT_W-1:0]  w_cntLoadVal;
  logic [CNT_W-1:0]  w_cntValue;
  logic              w_cntZero;

  ow_tick_counter #(
    .W(CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_cntLoad),
    .i_value (w_cntLoadVal),
    .o_value (w_cntValue),
    .o_zero  (w_cntZero)
  );

  // Two-flop synchroniser for the asynchronous line level; idles high like the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dqMeta <= 1'b1;
      r_dqSync <= 1'b1;
    end else begin
      r_dqMeta <= dq_in;
      r_dqSync <= r_dqMeta;
    end
  end

  assign w_presSample = (r_state == RST_WAIT) && (w_cntValue == L_PRES_AT);

  // Next-state decode, interval loads for the tick counter and address/count updates.
  always_comb begin
    w_nextState  = r_state;
    w_nextAddr   = r_addr;
    w_nextRemain = r_remain;
    w_cntLoad    = 1'b0;
    w_cntLoadVal = '0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_advanceBit = 1'b0;
    w_setPresErr = 1'b0;
    w_setReadErr = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_nextAddr   = start_addr;
          w_nextRemain = byte_count;
          if (with_reset) begin
            w_nextState  = RST_LOW;
            w_cntLoad    = 1'b1;
            w_cntLoadVal = L_RST_LOW;
          end else if (byte_count != '0) begin
            w_nextState = FETCH;
          end else begin
            w_nextState = FINISH;
          end
        end
      end

      RST_LOW: begin
        if (w_cntZero) begin
          w_nextState  = RST_WAIT;
          w_cntLoad    = 1'b1;
          w_cntLoadVal = L_RST_WAIT;
        end
      end

      RST_WAIT: begin
        if (w_cntZero) begin
          if (!r_presence) begin
            w_nextState  = FINISH;
            w_setPresErr = 1'b1;
          end else if (r_remain != '0) begin
            w_nextState = FETCH;
          end else begin
            w_nextState = FINISH;
          end
        end
      end

      FETCH: begin
        w_nextState  = WAIT_DATA;
        w_cntLoad    = 1'b1;
        w_cntLoadVal = L_RD_TO;
      end

      WAIT_DATA: begin
        if (data_dv) begin
          w_capture    = 1'b1;
          w_nextState  = SLOT_LOW;
          w_cntLoad    = 1'b1;
          w_cntLoadVal = data_out[0] ? L_LOW1 : L_LOW0;
        end else if (w_cntZero) begin
          w_nextState  = FINISH;
          w_setReadErr = 1'b1;
        end
      end

      SLOT_LOW: begin
        if (w_cntZero) begin
          w_nextState  = SLOT_REL;
          w_cntLoad    = 1'b1;
          w_cntLoadVal = r_shift[0] ? L_REL1 : L_REL0;
        end
      end

      SLOT_REL: begin
        if (w_cntZero) begin
          if (r_bitIdx == 3'd7) begin
            w_nextState = NEXT;
          end else begin
            w_nextState  = SLOT_LOW;
            w_advanceBit = 1'b1;
            w_cntLoad    = 1'b1;
            w_cntLoadVal = r_shift[1] ? L_LOW1 : L_LOW0;
          end
        end
      end

      NEXT: begin
        w_nextAddr   = r_addr + ADDR_W'(1);
        w_nextRemain = r_remain - BCNT_W'(1);
        if (r_remain > BCNT_W'(1)) begin
          w_nextState = FETCH;
        end else begin
          w_nextState = FINISH;
        end
      end

      FINISH: begin
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register plus the datapath that the decode above steers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_shift    <= '0;
      r_bitIdx   <= '0;
      r_presence <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_addr   <= w_nextAddr;
      r_remain <= w_nextRemain;
      if (w_capture) begin
        r_shift  <= data_out;
        r_bitIdx <= '0;
      end else if (w_advanceBit) begin
        r_shift  <= r_shift >> 1;
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      if (w_accept) begin
        r_presence <= 1'b0;
      end else if (w_presSample) begin
        r_presence <= ~r_dqSync;
      end
    end
  end

  // Outputs are registered from the next state so the bus line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readAddress <= '0;
      r_readEn      <= 1'b0;
      r_dqPullLow   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_presErr     <= 1'b0;
      r_readErr     <= 1'b0;
    end else begin
      r_readEn    <= (w_nextState == FETCH);
      r_dqPullLow <= (w_nextState == RST_LOW) || (w_nextState == SLOT_LOW);
      r_busy      <= (w_nextState != IDLE);
      r_done      <= (w_nextState == FINISH);
      if (w_nextState == FETCH) begin
        r_readAddress <= w_nextAddr;
      end
      if (w_accept) begin
        r_presErr <= 1'b0;
        r_readErr <= 1'b0;
      end else begin
        if (w_setPresErr) begin
          r_presErr <= 1'b1;
        end
        if (w_setReadErr) begin
          r_readErr <= 1'b1;
        end
      end
    end
  end

  assign read_address = r_readAddress;
  assign read_en      = r_readEn;
  assign dq_pull_low  = r_dqPullLow;
  assign busy         = r_busy;
  assign done         = r_done;
  assign presence_err = r_presErr;
  assign read_err     = r_readErr;

endmodule

// File: tb/tb_ow_tx_sequencer.sv
`timescale 1ns/1ps
// tb_ow_tx_sequencer: vector table plus random transactions against a
// byte-level model of the 1-wire write sequence, with a 3-cycle memory.
module tb_ow_tx_sequencer;

  localparam int T_SLOT    = 20;
  localparam int T_LOW1    = 2;
  localparam int T_LOW0    = 15;
  localparam int T_RST_LOW = 40;
  localparam int T_PRES    = 6;
  localparam int T_RST_TOT = 80;
  localparam int T_RD_TO   = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       with_reset;
  logic [4:0] start_addr;
  logic [5:0] byte_count;
  logic [4:0] read_address;
  logic       read_en;
  logic [7:0] data_out = 8'h00;
  logic       data_dv = 1'b0;
  logic       dq_in = 1'b1;
  logic       dq_pull_low;
  logic       busy;
  logic       done;
  logic       presence_err;
  logic       read_err;

  typedef struct {
    logic       withReset;
    logic [4:0] addr;
    logic [5:0] count;
    logic       presence;
    logic       respond;
    logic       expPresErr;
    logic       expReadErr;
    int         expReads;
    int         expDoneOff;
    string      name;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int acceptCycle = 0;
  int doneCycle = 0;
  int doneCount = 0;
  logic memRespond = 1'b1;
  logic presenceEnable = 1'b0;

  int lowWidths[$];
  int lowStart[$];
  int readLog[$];
  int expWidths[$];
  int expAddrs[$];

  logic prevPull = 1'b0;
  int   curRun = 0;
  int   presDelay = 0;
  int   presLen = 0;
  int   memCountdown = 0;
  int   memAddr = 0;

  ow_tx_sequencer #(
    .T_SLOT    (T_SLOT),
    .T_LOW1    (T_LOW1),
    .T_LOW0    (T_LOW0),
    .T_RST_LOW (T_RST_LOW),
    .T_PRES    (T_PRES),
    .T_RST_TOT (T_RST_TOT),
    .T_RD_TO   (T_RD_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .with_reset   (with_reset),
    .start_addr   (start_addr),
    .byte_count   (byte_count),
    .read_address (read_address),
    .read_en      (read_en),
    .data_out     (data_out),
    .data_dv      (data_dv),
    .dq_in        (dq_in),
    .dq_pull_low  (dq_pull_low),
    .busy         (busy),
    .done         (done),
    .presence_err (presence_err),
    .read_err     (read_err)
  );

  // 10 ns clock and a running edge count used for latency measurements.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Bus observer, presence-pulse slave and 3-cycle memory, all sampled on the falling edge.
  always @(negedge clk) begin
    if (dq_pull_low) begin
      if (!prevPull) begin
        lowStart.push_back(cycleCount);
        curRun = 0;
      end
      curRun++;
    end else if (prevPull) begin
      lowWidths.push_back(curRun);
      if (curRun >= 30 && presenceEnable) begin
        presDelay = 2;
        presLen   = 15;
      end
    end
    prevPull = dq_pull_low;

    if (presDelay > 0) begin
      presDelay--;
    end else if (presLen > 0) begin
      dq_in = 1'b0;
      presLen--;
    end else begin
      dq_in = 1'b1;
    end

    if (done) begin
      doneCount++;
      doneCycle = cycleCount;
    end

    data_dv = 1'b0;
    if (memCountdown > 0) begin
      memCountdown--;
      if (memCountdown == 0) begin
        data_dv  = 1'b1;
        data_out = mem[memAddr];
      end
    end
    if (read_en) begin
      readLog.push_back(int'(read_address));
      if (memRespond) begin
        memAddr      = int'(read_address);
        memCountdown = 3;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget (errors so far=%0d)", errors);
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearLogs();
    lowWidths.delete();
    lowStart.delete();
    readLog.delete();
    doneCount = 0;
    doneCycle = 0;
  endtask

  // Byte-level model: reset pulse first, then LSB-first low widths per fetched byte.
  task automatic buildExpected(input vec_t v);
    int a;
    bit sendBytes;
    expWidths.delete();
    expAddrs.delete();
    sendBytes = 1'b1;
    if (v.withReset) begin
      expWidths.push_back(T_RST_LOW);
      if (!v.presence) sendBytes = 1'b0;
    end
    if (sendBytes) begin
      for (int k = 0; k < int'(v.count); k++) begin
        a = (int'(v.addr) + k) % 32;
        expAddrs.push_back(a);
        if (!v.respond) break;
        for (int b = 0; b < 8; b++) begin
          expWidths.push_back(mem[a][b] ? T_LOW1 : T_LOW0);
        end
      end
    end
  endtask

  task automatic waitDone(input string name);
    int waited;
    waited = 0;
    while (doneCount == 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (doneCount == 0) checkOutput({name, ".doneSeenInTime"}, 0, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    clearLogs();
    memRespond     = v.respond;
    presenceEnable = v.presence;
    @(negedge clk);
    start      = 1'b1;
    with_reset = v.withReset;
    start_addr = v.addr;
    byte_count = v.count;
    @(posedge clk);
    #1;
    acceptCycle = cycleCount;
    checkOutput({v.name, ".busyAfterAccept"}, busy, 1);
    checkOutput({v.name, ".errClearedOnAccept"}, presence_err | read_err, 0);
    @(negedge clk);
    start      = 1'b0;
    with_reset = 1'b0;
    byte_count = 6'd0;
    waitDone(v.name);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResults(input vec_t v);
    int n;
    int off;
    int bad;
    buildExpected(v);
    checkOutput({v.name, ".doneCount"}, doneCount, 1);
    if (v.expDoneOff >= 0) checkOutput({v.name, ".doneOffset"}, doneCycle - acceptCycle, v.expDoneOff);
    checkOutput({v.name, ".presenceErr"}, presence_err, v.expPresErr);
    checkOutput({v.name, ".readErr"}, read_err, v.expReadErr);
    checkOutput({v.name, ".busyCleared"}, busy, 0);
    checkOutput({v.name, ".busReleased"}, dq_pull_low, 0);
    checkOutput({v.name, ".readCount"}, readLog.size(), v.expReads);
    n = (readLog.size() < expAddrs.size()) ? readLog.size() : expAddrs.size();
    for (int i = 0; i < n; i++) checkOutput({v.name, ".readAddr"}, readLog[i], expAddrs[i]);
    if (expAddrs.size() > 0) checkOutput({v.name, ".addrHold"}, read_address, expAddrs[$]);
    checkOutput({v.name, ".lowPulseCount"}, lowWidths.size(), expWidths.size());
    n = (lowWidths.size() < expWidths.size()) ? lowWidths.size() : expWidths.size();
    for (int i = 0; i < n; i++) checkOutput({v.name, ".lowWidth"}, lowWidths[i], expWidths[i]);
    off = v.withReset ? 1 : 0;
    if (lowStart.size() == expWidths.size() && expWidths.size() > off) begin
      bad = 0;
      for (int i = off + 1; i < lowStart.size(); i++) begin
        if ((i - off) % 8 != 0 && lowStart[i] - lowStart[i-1] != T_SLOT) bad++;
      end
      checkOutput({v.name, ".badSlotPeriods"}, bad, 0);
    end
  endtask

  initial begin
    vec_t rv;

    reset      = 1'b1;
    start      = 1'b0;
    with_reset = 1'b0;
    start_addr = 5'd0;
    byte_count = 6'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'((i * 37 + 11) & 255);
    mem[3] = 8'hA5;

    repeat (3) @(negedge clk);
    checkOutput("reset.dq_pull_low", dq_pull_low, 0);
    checkOutput("reset.read_en", read_en, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.presence_err", presence_err, 0);
    checkOutput("reset.read_err", read_err, 0);
    checkOutput("reset.read_address", read_address, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    vecs[0] = '{1'b0, 5'd3,  6'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1, -1, "singleA5"};
    vecs[1] = '{1'b1, 5'd0,  6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 80, "resetPresence"};
    vecs[2] = '{1'b1, 5'd7,  6'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 80, "resetNoPresence"};
    vecs[3] = '{1'b0, 5'd31, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2, -1, "addrWrap"};
    vecs[4] = '{1'b0, 5'd9,  6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1, 16, "readTimeout"};
    vecs[5] = '{1'b0, 5'd4,  6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0,  "zeroBytes"};
    vecs[6] = '{1'b1, 5'd12, 6'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1, -1, "resetThenByte"};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkResults(vecs[i]);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      rv.withReset  = 1'($urandom_range(0, 1));
      rv.addr       = 5'($urandom_range(0, 31));
      rv.count      = 6'($urandom_range(1, 3));
      rv.presence   = 1'b1;
      rv.respond    = 1'b1;
      rv.expPresErr = 1'b0;
      rv.expReadErr = 1'b0;
      rv.expReads   = int'(rv.count);
      rv.expDoneOff = -1;
      rv.name       = $sformatf("random%0d", r);
      applyStimulus(rv);
      checkResults(rv);
    end

    clearLogs();
    memRespond     = 1'b1;
    presenceEnable = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    with_reset = 1'b0;
    start_addr = 5'd3;
    byte_count = 6'd1;
    @(negedge clk);
    start      = 1'b0;
    byte_count = 6'd0;
    begin
      int waited;
      waited = 0;
      while (!dq_pull_low && waited < 200) begin
        @(negedge clk);
        waited++;
      end
    end
    checkOutput("midReset.inSlotLow", dq_pull_low, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midReset.busReleased", dq_pull_low, 0);
    checkOutput("midReset.busyCleared", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    clearLogs();
    repeat (60) @(negedge clk);
    checkOutput("midReset.noDone", doneCount, 0);
    checkOutput("midReset.noFurtherPulses", lowStart.size(), 0);
    checkOutput("midReset.noFurtherReads", readLog.size(), 0);

    clearLogs();
    presenceEnable = 1'b1;
    @(negedge clk);
    start      = 1'b1;
    with_reset = 1'b1;
    start_addr = 5'd0;
    byte_count = 6'd0;
    @(posedge clk);
    #1;
    acceptCycle = cycleCount;
    @(negedge clk);
    start      = 1'b0;
    with_reset = 1'b0;
    repeat (10) @(negedge clk);
    start      = 1'b1;
    start_addr = 5'd5;
    byte_count = 6'd2;
    @(negedge clk);
    start      = 1'b0;
    byte_count = 6'd0;
    waitDone("busyStart");
    checkOutput("busyStart.doneOffset", doneCycle - acceptCycle, 80);
    checkOutput("busyStart.noReads", readLog.size(), 0);
    checkOutput("busyStart.onlyResetPulse", lowWidths.size(), 1);
    checkOutput("busyStart.presenceErr", presence_err, 0);
    repeat (100) @(negedge clk);
    checkOutput("busyStart.singleDone", doneCount, 1);
    checkOutput("busyStart.stillNoReads", readLog.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ow_tx_sequencer.md
OW_TX_SEQUENCER -- requirements
Module: ow_tx_sequencer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- T_SLOT, 3500, write-slot length in clk cycles.
- T_LOW1, 300, low time for a '1' bit.
- T_LOW0, 3000, low time for a '0' bit.
- T_RST_LOW, 24000, reset-pulse low time.
- T_PRES, 3500, cycles from release to presence sample.
- T_RST_TOT, 48000, total reset sequence length.
- T_RD_TO, 15, data_dv timeout.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle request.
- with_reset, in, 1, prepend bus reset/presence.
- start_addr, in, 5, first memory address.
- byte_count, in, 6, bytes to send (0..32).
- read_address, out, 5, memory read address.
- read_en, out, 1, memory read request.
- data_out, in, 8, memory read data.
- data_dv, in, 1, read-data-valid pulse.
- dq_in, in, 1, raw 1-wire line level (asynchronous).
- dq_pull_low, out, 1, 1 = drive line low, 0 = release.
- busy, out, 1, sequence active.
- done, out, 1, one-cycle completion pulse.
- presence_err, out, 1, no presence detected.
- read_err, out, 1, data_dv timeout.
REQ-003 Clock is clk alone; reset is synchronous and active-high, named reset.

Function
REQ-004 States SHALL be IDLE, RST_LOW, RST_WAIT, FETCH, WAIT_DATA, SLOT_LOW, SLOT_REL, NEXT, FINISH.
REQ-005 start is accepted only in IDLE. Acceptance latches start_addr, byte_count and with_reset, and sets busy on the next edge. start while busy is ignored.
REQ-006 After acceptance, with_reset=1 goes to RST_LOW. Otherwise the block goes to FETCH if byte_count>0, else to FINISH.
REQ-007 RST_LOW drives dq_pull_low=1 for T_RST_LOW cycles, then releases and enters RST_WAIT.
REQ-008 RST_WAIT samples the synchronised dq_in at T_PRES cycles after release. Low = presence.
REQ-009 RST_WAIT always runs to T_RST_TOT total, then goes to FETCH or FINISH per byte_count. If presence was absent, it goes to FINISH with presence_err=1 and sends no bytes.
REQ-010 FETCH drives read_en=1 for exactly one cycle with read_address = current address, then enters WAIT_DATA.
REQ-011 WAIT_DATA captures data_out on the first cycle data_dv=1, then enters SLOT_LOW with bit index 0. data_dv is ignored in all other states.
REQ-012 If WAIT_DATA sees no data_dv within T_RD_TO cycles, the block goes to FINISH with read_err=1 and dq_pull_low=0.
REQ-013 Bits are sent LSB first. SLOT_LOW drives low for T_LOW1 (bit=1) or T_LOW0 (bit=0). SLOT_REL releases for T_SLOT minus that low time.
REQ-014 After bit 7 the block enters NEXT. NEXT increments the address modulo 32 (31 wraps to 0) and decrements the remaining count. It then goes to FETCH if the count is nonzero, else FINISH.
REQ-015 FINISH pulses done=1 for one cycle, clears busy, and returns to IDLE.
REQ-016 presence_err and read_err hold until the next accepted start, which clears both.
REQ-017 read_address holds its last value when read_en=0.
REQ-018 dq_in passes through a 2-flop synchroniser before any use.

Reset
REQ-019 Reset values: state IDLE, dq_pull_low=0, read_en=0, busy=0, done=0, presence_err=0, read_err=0, read_address=0.
REQ-020 Reset asserted mid-sequence releases the bus at the next edge and discards the latched request and any captured byte.

Structure
REQ-021 A shared package ow_pkg SHALL hold the state encoding, ADDR_W=5, DATA_W=8, CNT_W=16 and the default timing constants.
REQ-022 The timing down-counter SHALL be the sub-module ow_tick_counter, with load, value and zero-flag outputs, reused for all intervals.

Verification
All scenarios use T_SLOT=20, T_LOW1=2, T_LOW0=15, T_RST_LOW=40, T_PRES=6, T_RST_TOT=80 and a behavioural memory model with 3-cycle data_dv latency.
REQ-023 Single byte: start_addr=3, byte_count=1, mem[3]=0xA5, with_reset=0 -> low widths 2,15,2,15,15,2,15,2 (LSB first), 20-cycle slots, one done pulse, no errors.
REQ-024 Reset with presence: with_reset=1, byte_count=0, dq_in low in window -> 40-cycle low, done at 80 cycles, presence_err=0.
REQ-025 Reset without presence: with_reset=1, byte_count=2, dq_in held high -> presence_err=1, zero read_en pulses, done.
REQ-026 Wrap: start_addr=31, byte_count=2 -> read_en at addresses 31 then 0, 16 slots.
REQ-027 Memory never responds -> read_err=1 after 15 cycles, bus released, done.
REQ-028 Reset asserted during SLOT_LOW -> dq_pull_low=0 next edge, busy=0; start during busy -> ignored.
